// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator: standard mode timings,
// colour-bar palette and sync-polarity encoding.
package video_timing_pkg;

   localparam int unsigned CntW = 12;
   localparam int unsigned RgbW = 24;
   localparam int          NumBars = 8;

   // 1280x720p60, 74.25 MHz pixel clock
   localparam int unsigned H720Sync  = 40;
   localparam int unsigned H720Back  = 220;
   localparam int unsigned H720Disp  = 1280;
   localparam int unsigned H720Front = 110;
   localparam int unsigned V720Sync  = 5;
   localparam int unsigned V720Back  = 20;
   localparam int unsigned V720Disp  = 720;
   localparam int unsigned V720Front = 5;

   // 640x480p60, 25.175 MHz pixel clock (syncs active-low)
   localparam int unsigned H480Sync  = 96;
   localparam int unsigned H480Back  = 48;
   localparam int unsigned H480Disp  = 640;
   localparam int unsigned H480Front = 16;
   localparam int unsigned V480Sync  = 2;
   localparam int unsigned V480Back  = 33;
   localparam int unsigned V480Disp  = 480;
   localparam int unsigned V480Front = 10;

   typedef enum logic {
      SyncActiveLow  = 1'b0,
      SyncActiveHigh = 1'b1
   } sync_pol_e;

   localparam logic [RgbW-1:0] ColWhite   = 24'hFFFFFF;
   localparam logic [RgbW-1:0] ColYellow  = 24'hFFFF00;
   localparam logic [RgbW-1:0] ColCyan    = 24'h00FFFF;
   localparam logic [RgbW-1:0] ColGreen   = 24'h00FF00;
   localparam logic [RgbW-1:0] ColMagenta = 24'hFF00FF;
   localparam logic [RgbW-1:0] ColRed     = 24'hFF0000;
   localparam logic [RgbW-1:0] ColBlue    = 24'h0000FF;
   localparam logic [RgbW-1:0] ColBlack   = 24'h000000;

   // Bars run left to right in decreasing luminance order.
   function automatic logic [RgbW-1:0] bar_color(input logic [2:0] idx);
      logic [RgbW-1:0] col;
      unique case (idx)
         3'd0: col = ColWhite;
         3'd1: col = ColYellow;
         3'd2: col = ColCyan;
         3'd3: col = ColGreen;
         3'd4: col = ColMagenta;
         3'd5: col = ColRed;
         3'd6: col = ColBlue;
         3'd7: col = ColBlack;
      endcase
      return col;
   endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel fetch port between the timing generator (master) and the frame-buffer
// read FIFO (slave). Data returns exactly one cycle after pixel_req.
interface video_timing_gen_if;
   import video_timing_pkg::*;

   logic            pixel_req;
   logic [CntW-1:0] pixel_xpos;
   logic [CntW-1:0] pixel_ypos;
   logic [RgbW-1:0] pixel_data;

   modport master (
      output pixel_req,
      output pixel_xpos,
      output pixel_ypos,
      input  pixel_data
   );

   modport slave (
      input  pixel_req,
      input  pixel_xpos,
      input  pixel_ypos,
      output pixel_data
   );

endinterface

// File: rtl/colorbar_gen.sv
// Eight-bar colour pattern: maps an active-area column to its bar colour,
// registered, one cycle of latency.
module colorbar_gen
   import video_timing_pkg::*;
#(
   parameter int unsigned H_DISP = H720Disp
) (
   input  logic            pclk,
   input  logic            reset,
   input  logic [CntW-1:0] col_i,
   output logic [RgbW-1:0] rgb_o
);

   logic [2:0]      bar_idx;
   logic [RgbW-1:0] rgb_d, rgb_q;

   // Bar index by comparison against constant bar edges (no divider).
   always_comb begin
      bar_idx = '0;
      for (int k = 1; k < NumBars; k++) begin
         if (col_i >= CntW'(k * H_DISP / NumBars)) begin
            bar_idx = 3'(k);
         end
      end
      rgb_d = bar_color(bar_idx);
   end

   // Output register.
   always_ff @(posedge pclk) begin
      if (reset) begin
         rgb_q <= '0;
      end else begin
         rgb_q <= rgb_d;
      end
   end

   assign rgb_o = rgb_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, one-cycle-ahead pixel fetch requests,
// and a two-stage pipeline that aligns returned pixels (or colour bars) with
// hsync/vsync/de.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int unsigned H_SYNC   = H720Sync,
   parameter int unsigned H_BACK   = H720Back,
   parameter int unsigned H_DISP   = H720Disp,
   parameter int unsigned H_FRONT  = H720Front,
   parameter int unsigned V_SYNC   = V720Sync,
   parameter int unsigned V_BACK   = V720Back,
   parameter int unsigned V_DISP   = V720Disp,
   parameter int unsigned V_FRONT  = V720Front,
   parameter bit          SYNC_POL = 1'b1
) (
   input  logic                      pclk,
   input  logic                      reset,
   input  logic                      pattern_sel,
   video_timing_gen_if.master        pix,
   output logic                      frame_start,
   output logic [RgbW-1:0]           video_rgb,
   output logic                      video_hsync,
   output logic                      video_vsync,
   output logic                      video_de
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
   localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

   localparam logic [CntW-1:0] HLast     = CntW'(H_TOTAL - 1);
   localparam logic [CntW-1:0] VLast     = CntW'(V_TOTAL - 1);
   localparam logic [CntW-1:0] HSyncEnd  = CntW'(H_SYNC);
   localparam logic [CntW-1:0] VSyncEnd  = CntW'(V_SYNC);
   localparam logic [CntW-1:0] HActStart = CntW'(H_SYNC + H_BACK);
   localparam logic [CntW-1:0] VActStart = CntW'(V_SYNC + V_BACK);
   localparam logic [CntW-1:0] HActEnd   = CntW'(H_SYNC + H_BACK + H_DISP);
   localparam logic [CntW-1:0] VActEnd   = CntW'(V_SYNC + V_BACK + V_DISP);

   localparam logic SyncOn  = SYNC_POL;
   localparam logic SyncOff = ~SYNC_POL;

   // Counters
   logic [CntW-1:0] h_cnt_d, h_cnt_q;
   logic [CntW-1:0] v_cnt_d, v_cnt_q;

   // Stage 0 (combinational)
   logic            h_act, v_act, act_c, req_c, frame_start_c;
   logic [CntW-1:0] xpos_c, ypos_c;
   logic            pat_d, pat_q;

   // Stage 1
   logic            hs1_d, hs1_q, vs1_d, vs1_q, de1_d, de1_q, pat1_q;
   logic [CntW-1:0] col1_q;

   // Stage 2
   logic            hs2_q, vs2_q, de2_q, pat2_q;
   logic [RgbW-1:0] data2_d, data2_q;
   logic [RgbW-1:0] bar_rgb;

   // Raster counters: h wraps at end of line, v advances only on h wrap.
   always_comb begin
      h_cnt_d = h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == HLast) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 1'b1;
      end
   end

   // Counter state.
   always_ff @(posedge pclk) begin
      if (reset) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Stage 0 decode; requests and frame_start are held low while in reset.
   always_comb begin
      h_act         = (h_cnt_q >= HActStart) && (h_cnt_q < HActEnd);
      v_act         = (v_cnt_q >= VActStart) && (v_cnt_q < VActEnd);
      act_c         = h_act && v_act;
      req_c         = act_c && !reset;
      frame_start_c = (h_cnt_q == '0) && (v_cnt_q == '0) && !reset;
      xpos_c        = req_c ? (h_cnt_q - HActStart) : '0;
      ypos_c        = req_c ? (v_cnt_q - VActStart) : '0;
      // Pattern select only changes at a frame boundary to avoid tearing.
      pat_d         = frame_start_c ? pattern_sel : pat_q;
   end

   assign pix.pixel_req  = req_c;
   assign pix.pixel_xpos = xpos_c;
   assign pix.pixel_ypos = ypos_c;
   assign frame_start    = frame_start_c;

   // Stage 1 next-state: sync/de decode mapped through the sync polarity.
   always_comb begin
      hs1_d = (h_cnt_q < HSyncEnd) ? SyncOn : SyncOff;
      vs1_d = (v_cnt_q < VSyncEnd) ? SyncOn : SyncOff;
      de1_d = act_c;
   end

   // Stage 2 next-state: capture FIFO data, which lines up with stage 1.
   always_comb begin
      data2_d = de1_q ? pix.pixel_data : '0;
   end

   // Pattern latch and both pipeline stages.
   always_ff @(posedge pclk) begin
      if (reset) begin
         pat_q   <= 1'b0;
         hs1_q   <= SyncOff;
         vs1_q   <= SyncOff;
         de1_q   <= 1'b0;
         pat1_q  <= 1'b0;
         col1_q  <= '0;
         hs2_q   <= SyncOff;
         vs2_q   <= SyncOff;
         de2_q   <= 1'b0;
         pat2_q  <= 1'b0;
         data2_q <= '0;
      end else begin
         pat_q   <= pat_d;
         hs1_q   <= hs1_d;
         vs1_q   <= vs1_d;
         de1_q   <= de1_d;
         pat1_q  <= pat_q;
         col1_q  <= xpos_c;
         hs2_q   <= hs1_q;
         vs2_q   <= vs1_q;
         de2_q   <= de1_q;
         pat2_q  <= pat1_q;
         data2_q <= data2_d;
      end
   end

   colorbar_gen #(
      .H_DISP (H_DISP)
   ) u_colorbar_gen (
      .pclk  (pclk),
      .reset (reset),
      .col_i (col1_q),
      .rgb_o (bar_rgb)
   );

   // Output select; blanking forces black regardless of source.
   always_comb begin
      video_rgb = '0;
      if (de2_q) begin
         video_rgb = pat2_q ? bar_rgb : data2_q;
      end
   end

   assign video_hsync = hs2_q;
   assign video_vsync = vs2_q;
   assign video_de    = de2_q;

endmodule
